// File: rtl/shift_seq.sv
// shift_seq: iterative shift sequencer driving an external combinational shifter.
// A command (operand, shift amount, direction, arithmetic select, pass count) is
// accepted in IDLE. In RUN the operand is fed through the external shifter once per
// cycle, and the shifter result is written back. After the last pass the block holds
// the result in DONE until the consumer takes it.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    command handshake
//   in_din[7:0]          operand
//   in_shamt[2:0]        shift amount per pass
//   in_lr                1 = left, 0 = right
//   in_al                1 = arithmetic (right shifts only)
//   in_rep[2:0]          number of passes, 0 treated as 1
//   sh_din/sh_shamt/sh_lr/sh_al  operand and controls to the external shifter
//   sh_dout[7:0]         shifter result (combinational from sh_*)
//   out_valid/out_ready  result handshake
//   out_data[7:0]        result
//   busy                 high whenever not IDLE
module shift_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_din,
  input  logic [2:0] in_shamt,
  input  logic       in_lr,
  input  logic       in_al,
  input  logic [2:0] in_rep,
  output logic [7:0] sh_din,
  output logic [2:0] sh_shamt,
  output logic       sh_lr,
  output logic       sh_al,
  input  logic [7:0] sh_dout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] shamt_q, shamt_d;
  logic       lr_q, lr_d;
  logic       al_q, al_d;

  // State and datapath registers; reset wins over any pass or handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      shamt_q <= '0;
      lr_q    <= 1'b0;
      al_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      shamt_q <= shamt_d;
      lr_q    <= lr_d;
      al_q    <= al_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    shamt_d = shamt_q;
    lr_d    = lr_q;
    al_d    = al_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_din;
          shamt_d = in_shamt;
          lr_d    = in_lr;
          al_d    = in_al;
          cnt_d   = (in_rep == 3'd0) ? 3'd1 : in_rep;
          state_d = RUN;
        end
      end
      RUN: begin
        // One shifter pass per cycle; the last pass is the one with cnt_q == 1.
        data_d = sh_dout;
        cnt_d  = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs. in_ready is masked by rst so no handshake appears to complete
  // on an edge where reset discards the command.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_data  = data_q;
    sh_din    = data_q;
    sh_shamt  = shamt_q;
    sh_lr     = lr_q;
    sh_al     = al_q;
  end

endmodule
